// File: rtl/rs_alloc_issue_ctrl_pkg.sv
// Shared sizing for the reservation-station allocate/issue controller.
// Holds the default entry count and the index-width helper used by every file.
package rs_alloc_issue_ctrl_pkg;

  localparam int RS_SIZE = 8;

  // Index width that stays at least 1 bit even for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int RS_IDX_W = idx_w(RS_SIZE);

endpackage

// File: rtl/rs_alloc_issue_ctrl_rr_priority_sel.sv
// Rotating priority encoder: first set bit of req at or above ptr, wrapping.
// Purely combinational, 0-cycle; no flow control of its own.
module rr_priority_sel
  import rs_alloc_issue_ctrl_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         vld,
  output logic [W-1:0] idx
);

  logic [W-1:0] pos;

  // N is a power of two, so W-bit addition wraps modulo N for free.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = ptr + W'(i);
      if (!vld && req[pos]) begin
        vld = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/rs_alloc_issue_ctrl.sv
// RS allocate/issue controller: 0-cycle lowest-free allocation and round-robin issue gated by fu_ready.
// Dispatch stalls via rs_full; squash clears all entries. Optional perf counters under RS_PERF_CNT_EN.
module rs_alloc_issue_ctrl
  import rs_alloc_issue_ctrl_pkg::*;
#(
  parameter int N_ENTRIES = RS_SIZE,
  parameter int IDX_W     = idx_w(N_ENTRIES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dispatch_valid,
  input  logic [N_ENTRIES-1:0] entry_busy,
  input  logic [N_ENTRIES-1:0] entry_ready,
  input  logic                 fu_ready,
  input  logic                 squash,
  output logic [N_ENTRIES-1:0] entry_wr_en,
  output logic [N_ENTRIES-1:0] entry_clear,
  output logic                 issue_valid,
  output logic [IDX_W-1:0]     issue_idx,
  output logic                 rs_full,
  output logic [IDX_W:0]       free_count
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]          dispatch_stall_cnt,
  output logic [31:0]          issue_cnt
`endif
);

  localparam logic [N_ENTRIES-1:0] ONE_N   = N_ENTRIES'(1);
  localparam logic [IDX_W:0]       ONE_CNT = (IDX_W + 1)'(1);

  logic [IDX_W-1:0]     rr_ptr;
  logic [N_ENTRIES-1:0] cand;
  logic [N_ENTRIES-1:0] clr_issue;
  logic [N_ENTRIES-1:0] free;
  logic                 sel_vld;
  logic [IDX_W-1:0]     sel_idx;
  logic                 issue_go;
  logic [IDX_W:0]       idle_cnt;

  // Busy masking makes stray ready flags on empty entries harmless.
  assign cand = entry_busy & entry_ready;

  rr_priority_sel #(
    .N (N_ENTRIES),
    .W (IDX_W)
  ) u_rr_sel (
    .req (cand),
    .ptr (rr_ptr),
    .vld (sel_vld),
    .idx (sel_idx)
  );

  assign issue_go    = sel_vld & fu_ready & ~squash & ~reset;
  assign issue_valid = issue_go;
  assign issue_idx   = issue_go ? sel_idx : '0;

  always_comb begin
    clr_issue = '0;
    if (issue_go) clr_issue[sel_idx] = 1'b1;
  end

  assign entry_clear = (reset | squash) ? '1 : clr_issue;

  // The entry leaving this cycle still reads busy, but is excluded anyway so
  // dispatch and issue can never collide on one slot.
  assign free        = ~entry_busy & ~clr_issue;
  assign rs_full     = (free == '0);
  assign entry_wr_en = (dispatch_valid & ~squash & ~reset) ? (free & (~free + ONE_N)) : '0;

  always_comb begin
    idle_cnt = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!entry_busy[i]) idle_cnt = idle_cnt + ONE_CNT;
    end
  end

  assign free_count = idle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (squash) begin
      rr_ptr <= '0;
    end else if (issue_go) begin
      rr_ptr <= sel_idx + IDX_W'(1);
    end
  end

`ifdef RS_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dispatch_stall_cnt <= '0;
      issue_cnt          <= '0;
    end else begin
      if (dispatch_valid && rs_full && !squash && (dispatch_stall_cnt != 32'hFFFF_FFFF))
        dispatch_stall_cnt <= dispatch_stall_cnt + 32'd1;
      if (issue_go && (issue_cnt != 32'hFFFF_FFFF))
        issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_alloc_issue_ctrl.sv
// Bench for rs_alloc_issue_ctrl at 4 entries: directed vector table, random run vs. reference model.
// Perf-counter sequences are exercised when RS_PERF_CNT_EN is defined.
module tb_rs_alloc_issue_ctrl;

  localparam int N = 4;
  localparam int W = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         dispatch_valid = 1'b0;
  logic [N-1:0] entry_busy = '0;
  logic [N-1:0] entry_ready = '0;
  logic         fu_ready = 1'b0;
  logic         squash = 1'b0;
  logic [N-1:0] entry_wr_en;
  logic [N-1:0] entry_clear;
  logic         issue_valid;
  logic [W-1:0] issue_idx;
  logic         rs_full;
  logic [W:0]   free_count;
`ifdef RS_PERF_CNT_EN
  logic [31:0]  dispatch_stall_cnt;
  logic [31:0]  issue_cnt;
`endif

  rs_alloc_issue_ctrl #(.N_ENTRIES(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .entry_busy     (entry_busy),
    .entry_ready    (entry_ready),
    .fu_ready       (fu_ready),
    .squash         (squash),
    .entry_wr_en    (entry_wr_en),
    .entry_clear    (entry_clear),
    .issue_valid    (issue_valid),
    .issue_idx      (issue_idx),
    .rs_full        (rs_full),
    .free_count     (free_count)
`ifdef RS_PERF_CNT_EN
    ,
    .dispatch_stall_cnt (dispatch_stall_cnt),
    .issue_cnt          (issue_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the round-robin start point and the perf totals.
  int m_rr = 0;
  longint m_stall = 0;
  longint m_iss = 0;
  logic         e_iv;
  logic [W-1:0] e_idx;
  logic [N-1:0] e_wr, e_clr;
  logic         e_full;
  logic [W:0]   e_fc;

  typedef struct {
    logic [N-1:0] busy;
    logic [N-1:0] ready;
    logic         dv;
    logic         fu;
    logic         sq;
    logic [N-1:0] x_wr;
    logic [N-1:0] x_clr;
    logic         x_iv;
    logic [W-1:0] x_idx;
    logic         x_full;
    logic [W:0]   x_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] wr, input logic [N-1:0] clr,
                            input logic iv, input logic [W-1:0] idx, input logic full,
                            input logic [W:0] fc);
    check_val({tag, ".wr_en"},  32'(entry_wr_en), 32'(wr));
    check_val({tag, ".clear"},  32'(entry_clear), 32'(clr));
    check_val({tag, ".iv"},     32'(issue_valid), 32'(iv));
    check_val({tag, ".idx"},    32'(issue_idx),   32'(idx));
    check_val({tag, ".full"},   32'(rs_full),     32'(full));
    check_val({tag, ".fcount"}, 32'(free_count),  32'(fc));
  endtask

  // Expected outputs derived directly from the rules, using the modelled rr start point.
  task automatic model_eval();
    int cand, fr, clr_bit;
    cand = int'(entry_busy & entry_ready);
    e_iv = 1'b0;
    e_idx = '0;
    if (!reset && fu_ready && !squash && cand != 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!e_iv && ((cand >> j) & 1) == 1) begin
          e_iv = 1'b1;
          e_idx = W'(j);
        end
      end
    end
    clr_bit = e_iv ? (1 << e_idx) : 0;
    e_clr = (reset || squash) ? '1 : N'(clr_bit);
    fr = int'(~entry_busy) & ~clr_bit & ((1 << N) - 1);
    e_full = (fr == 0);
    e_fc = (W + 1)'($countones(~entry_busy));
    e_wr = '0;
    if (!reset && dispatch_valid && !squash) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (((fr >> j) & 1) == 1) e_wr = N'(1 << j);
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] busy, input logic [N-1:0] ready, input logic dv,
                       input logic fu, input logic sq, input logic rst);
    entry_busy = busy;
    entry_ready = ready;
    dispatch_valid = dv;
    fu_ready = fu;
    squash = sq;
    reset = rst;
  endtask

  // Moves the reference state across one clock edge, then settles 1 time unit past it.
  task automatic tick();
    logic stall;
    stall = dispatch_valid && e_full && !squash;
    @(posedge clock);
    if (reset || squash) m_rr = 0;
    else if (e_iv) m_rr = (int'(e_idx) + 1) % N;
    if (reset) begin
      m_stall = 0;
      m_iss = 0;
    end else begin
      if (stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_iv && m_iss < 64'hFFFF_FFFF) m_iss++;
    end
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] busy, input logic [N-1:0] ready, input logic dv,
                              input logic fu, input logic sq, input logic [N-1:0] wr,
                              input logic [N-1:0] clr, input logic iv, input logic [W-1:0] idx,
                              input logic full, input logic [W:0] fc);
    vec_t v;
    v.busy = busy; v.ready = ready; v.dv = dv; v.fu = fu; v.sq = sq;
    v.x_wr = wr; v.x_clr = clr; v.x_iv = iv; v.x_idx = idx; v.x_full = full; v.x_fc = fc;
    return v;
  endfunction

  initial begin
    // Applied in order; rr_ptr carries from row to row (noted after each row).
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 4)); // rr 0
    vecs.push_back(mk(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0)); // rr 0
    vecs.push_back(mk(4'b1111, 4'b0110, 0, 1, 0, 4'b0000, 4'b0010, 1, 1, 1, 0)); // rr 2
    vecs.push_back(mk(4'b1111, 4'b0110, 0, 1, 0, 4'b0000, 4'b0100, 1, 2, 1, 0)); // rr 3
    vecs.push_back(mk(4'b1111, 4'b0001, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 1, 0)); // rr 1
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0)); // rr holds 1
    vecs.push_back(mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0010, 1, 1, 1, 0)); // rr 2
    vecs.push_back(mk(4'b1011, 4'b1000, 1, 1, 0, 4'b0100, 4'b1000, 1, 3, 0, 1)); // rr 0
    vecs.push_back(mk(4'b1111, 4'b0010, 0, 1, 0, 4'b0000, 4'b0010, 1, 1, 1, 0)); // rr 2
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, 1, 4'b0000, 4'b1111, 0, 0, 1, 0)); // squash, rr 0
    vecs.push_back(mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 1, 0)); // rr 1
    vecs.push_back(mk(4'b0011, 4'b1100, 1, 1, 0, 4'b0100, 4'b0000, 0, 0, 0, 2)); // stray ready
    vecs.push_back(mk(4'b0101, 4'b0101, 1, 1, 0, 4'b0010, 4'b0100, 1, 2, 0, 2)); // rr 3
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 1, 1, 4'b0000, 4'b1111, 0, 0, 0, 4)); // squash idle

    // Reset held with live inputs: controls forced, occupancy still visible.
    drive(4'b0110, 4'b1111, 1, 1, 0, 1);
    #2;
    check_outs("in_reset", 4'b0000, 4'b1111, 0, 0, 0, 2);
    model_eval();
    tick();
    drive(4'b0000, 4'b0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].busy, vecs[i].ready, vecs[i].dv, vecs[i].fu, vecs[i].sq, 0);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].x_wr, vecs[i].x_clr, vecs[i].x_iv,
                 vecs[i].x_idx, vecs[i].x_full, vecs[i].x_fc);
      model_eval();
      tick();
    end

    // Random traffic against the reference model, with occasional squash and reset.
    for (int c = 0; c < 400; c++) begin
      drive(N'($urandom), N'($urandom), ($urandom % 4) != 0, ($urandom % 4) != 0,
            ($urandom % 16) == 0, ($urandom % 60) == 0);
      #2;
      model_eval();
      check_outs($sformatf("rnd%0d", c), e_wr, e_clr, e_iv, e_idx, e_full, e_fc);
`ifdef RS_PERF_CNT_EN
      check_val("rnd.stall_cnt", dispatch_stall_cnt, reset ? 32'd0 : 32'(m_stall));
      check_val("rnd.issue_cnt", issue_cnt, reset ? 32'd0 : 32'(m_iss));
`endif
      tick();
    end

`ifdef RS_PERF_CNT_EN
    drive(4'b0000, 4'b0000, 0, 0, 0, 1);
    model_eval();
    tick();
    drive(4'b1111, 4'b0000, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      model_eval();
      tick();
    end
    drive(4'b1111, 4'b0100, 0, 1, 0, 0);
    for (int c = 0; c < 2; c++) begin
      model_eval();
      tick();
    end
    drive(4'b0000, 4'b0000, 0, 0, 0, 0);
    #2;
    check_val("perf.stall_cnt", dispatch_stall_cnt, 32'd3);
    check_val("perf.issue_cnt", issue_cnt, 32'd2);
    reset = 1'b1;
    #1;
    check_val("perf.stall_rst", dispatch_stall_cnt, 32'd0);
    check_val("perf.issue_rst", issue_cnt, 32'd0);
    model_eval();
    tick();
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
